// File: rtl/seq_signed_divider_pkg.sv
// Shared definitions for the sequential signed divider: FSM encoding, default width, magnitude helper.
package div_pkg;

    localparam int N_DEF = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    // Magnitude of an n-bit two's-complement value held in the low bits of v.
    // The most negative value maps to 2^(n-1), which still fits in n unsigned bits.
    function automatic logic [63:0] abs_n(input logic [63:0] v, input int unsigned n);
        logic [63:0] mask;
        logic [63:0] r;
        mask = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
        r    = v & mask;
        if (r[n-1]) begin
            r = (~r + 64'd1) & mask;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_signed_divider_shift_right.sv
// Divisor shift register: load places the value at the top of a 2N-1 bit field, en shifts right by one.
// Single-cycle update; load has priority over en, no backpressure.
module shift_right
    import div_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           en,
    input  logic [N-1:0]   load_val,
    output logic [2*N-2:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= {load_val, {(N-1){1'b0}}};
        end else if (en) begin
            q <= q >> 1;
        end
    end

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential signed restoring divider, one quotient bit per clock; done pulses N+2 cycles after start (2 for /0).
// start is only taken in IDLE; requests while busy are dropped, not queued.
module seq_signed_divider
    import div_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int W  = 2*N - 1;
    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [N-1:0]  MIN_MAG  = {1'b1, {(N-1){1'b0}}};

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [W-1:0]  rem_reg;
    logic [W-1:0]  div_reg;
    logic [N-1:0]  q_reg;
    logic [N-1:0]  dvd_reg;
    logic [CW-1:0] cnt;
    logic          sign_q;
    logic          sign_r;
    logic          dz;
    logic          accept;
    logic          rem_ge;
    logic [N-1:0]  dvd_mag;
    logic [N-1:0]  dsr_mag;

    assign accept  = (state == ST_IDLE) && start;
    assign rem_ge  = (rem_reg >= div_reg);
    assign dvd_mag = N'(abs_n(64'(dividend), N));
    assign dsr_mag = N'(abs_n(64'(divisor), N));

    shift_right #(.N(N)) u_div_shift (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .en       (state == ST_RUN),
        .load_val (dsr_mag),
        .q        (div_reg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = (divisor == '0) ? ST_FIX : ST_RUN;
            ST_RUN:  if (cnt == CNT_LAST) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_reg     <= '0;
            q_reg       <= '0;
            dvd_reg     <= '0;
            cnt         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dz          <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sign_q      <= dividend[N-1] ^ divisor[N-1];
                        sign_r      <= dividend[N-1];
                        rem_reg     <= W'(dvd_mag);
                        q_reg       <= '0;
                        cnt         <= '0;
                        dvd_reg     <= dividend;
                        dz          <= (divisor == '0);
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (rem_ge) begin
                        rem_reg <= rem_reg - div_reg;
                    end
                    q_reg <= {q_reg[N-2:0], rem_ge};
                    cnt   <= cnt + 1'b1;
                end
                ST_FIX: begin
                    done <= 1'b1;
                    if (dz) begin
                        quotient    <= '1;
                        remainder   <= dvd_reg;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient  <= sign_q ? -q_reg : q_reg;
                        remainder <= sign_r ? -rem_reg[N-1:0] : rem_reg[N-1:0];
                        // A positive magnitude of 2^(N-1) cannot be represented; it wraps to the minimum.
                        overflow  <= (q_reg == MIN_MAG) && !sign_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Bench for seq_signed_divider (N=8): table vectors, multi-cycle corner sequences and a random sweep.
module tb_seq_signed_divider;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ovf;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ovf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;
    logic       overflow;

    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[14];

    seq_signed_divider #(.N(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   ai;
        int   bi;
        ai = int'($signed(a));
        bi = int'($signed(b));
        e.dz  = 1'b0;
        e.ovf = 1'b0;
        if (bi == 0) begin
            e.q  = 8'hFF;
            e.r  = a;
            e.dz = 1'b1;
        end else if (ai == -128 && bi == -1) begin
            e.q   = 8'h80;
            e.r   = 8'h00;
            e.ovf = 1'b1;
        end else begin
            e.q = 8'(ai / bi);
            e.r = 8'(ai % bi);
        end
        return e;
    endfunction

    // Results are compared against the scoreboard whenever the DUT signals done.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done actual=done required=no_done");
            end else begin
                mon_e = sb.pop_front();
                check("quotient", 32'(quotient), 32'(mon_e.q));
                check("remainder", 32'(remainder), 32'(mon_e.r));
                check("div_by_zero", 32'(div_by_zero), 32'(mon_e.dz));
                check("overflow", 32'(overflow), 32'(mon_e.ovf));
            end
        end
    end

    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input exp_t e);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int exp_lat);
        int cyc;
        int busy_cnt;
        bit seen;
        cyc = 0;
        busy_cnt = 0;
        seen = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done) begin
                cyc  = i;
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL done_timeout actual=no_done required=done_within_30");
            sb.delete();
        end else begin
            check("latency", 32'(cyc), 32'(exp_lat));
            check("busy_cycles", 32'(busy_cnt), 32'(exp_lat - 1));
            check("busy_in_done", 32'(busy), 32'd0);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_quotient"}, 32'(quotient), 32'd0);
        check({tag, "_remainder"}, 32'(remainder), 32'd0);
        check({tag, "_div_by_zero"}, 32'(div_by_zero), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        exp_t e;
        int   done_cnt;
        logic [7:0] ra;
        logic [7:0] rb;

        tbl[0]  = '{8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0};
        tbl[1]  = '{8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0};
        tbl[2]  = '{8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0};
        tbl[3]  = '{8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0};
        tbl[4]  = '{8'h03, 8'h64, 8'h00, 8'h03, 1'b0, 1'b0};
        tbl[5]  = '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1};
        tbl[6]  = '{8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0};
        tbl[7]  = '{8'h05, 8'h00, 8'hFF, 8'h05, 1'b1, 1'b0};
        tbl[8]  = '{8'h0A, 8'h03, 8'h03, 8'h01, 1'b0, 1'b0};
        tbl[9]  = '{8'h7F, 8'h80, 8'h00, 8'h7F, 1'b0, 1'b0};
        tbl[10] = '{8'h80, 8'h80, 8'h01, 8'h00, 1'b0, 1'b0};
        tbl[11] = '{8'h80, 8'h7F, 8'hFF, 8'hFF, 1'b0, 1'b0};
        tbl[12] = '{8'hFB, 8'h00, 8'hFF, 8'hFB, 1'b1, 1'b0};
        tbl[13] = '{8'h7F, 8'h7F, 8'h01, 8'h00, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        foreach (tbl[i]) begin
            e = '{tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].ovf};
            @(posedge clk);
            #1;
            start_op(tbl[i].a, tbl[i].b, e);
            wait_done((tbl[i].b == 8'h00) ? 2 : 10);
        end

        // start pulsed mid-RUN must be dropped: one result, original latency.
        @(posedge clk);
        #1;
        start_op(8'd100, 8'd7, '{8'd14, 8'd2, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        dividend = 8'd50;
        divisor  = 8'd5;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(8);

        // Reset in the middle of RUN discards the operation.
        @(posedge clk);
        #1;
        start_op(8'd100, 8'd7, '{8'd14, 8'd2, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        dividend = 8'd50;
        divisor  = 8'd5;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_zero("midrun_reset");
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("no_done_after_reset", 32'(done_cnt), 32'd0);
        @(posedge clk);
        #1;
        start_op(8'd50, 8'd5, '{8'd10, 8'd0, 1'b0, 1'b0});
        wait_done(10);

        // Back-to-back: new start asserted during the done cycle.
        @(posedge clk);
        #1;
        start_op(8'd100, 8'd7, '{8'd14, 8'd2, 1'b0, 1'b0});
        wait_done(10);
        start_op(8'd127, 8'd2, '{8'd63, 8'd1, 1'b0, 1'b0});
        wait_done(10);
        start_op(8'd5, 8'd0, '{8'hFF, 8'd5, 1'b1, 1'b0});
        wait_done(2);

        for (int i = 0; i < 1500; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            case ($urandom_range(0, 15))
                0: rb = 8'h00;
                1: ra = 8'h80;
                2: rb = 8'hFF;
                3: rb = 8'h01;
                default: ;
            endcase
            @(posedge clk);
            #1;
            start_op(ra, rb, model(ra, rb));
            wait_done((rb == 8'h00) ? 2 : 10);
        end

        repeat (4) @(posedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
